// File: rtl/pwm_ramp_ctrl.sv
// Slews the PWM duty toward a commanded target by one step per PWM period.
// Duty updates on the edge sampling period_tick; commands stall (cmd_ready=0) while ramping or during abort.
module pwm_ramp_ctrl #(
  parameter  int PERIOD = 100,
  parameter  int STEP_W = 8,
  localparam int DW     = $clog2(PERIOD + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              period_tick,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DW-1:0]     cmd_target,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic              abort,
  output logic [DW-1:0]     duty,
  output logic              busy,
  output logic              done
);

  // Step is held wide enough both for the raw field and for an unsigned |tgt-duty| compare.
  localparam int            SW   = (STEP_W > DW + 1) ? STEP_W : DW + 1;
  localparam logic [DW-1:0] MAXD = DW'(PERIOD);

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [DW-1:0] r_duty, w_duty_nxt;
  logic [DW-1:0] r_tgt, w_tgt_nxt;
  logic [SW-1:0] r_stp, w_stp_nxt;
  logic          r_done, w_done_nxt;
  logic [SW-1:0] w_dist;

  assign w_dist = (r_tgt >= r_duty) ? (SW'(r_tgt) - SW'(r_duty))
                                    : (SW'(r_duty) - SW'(r_tgt));

  assign cmd_ready = (r_state == IDLE) && !abort;
  assign duty      = r_duty;
  assign busy      = (r_state == RAMP);
  assign done      = r_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_duty  <= '0;
      r_tgt   <= '0;
      r_stp   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_duty  <= w_duty_nxt;
      r_tgt   <= w_tgt_nxt;
      r_stp   <= w_stp_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_tgt_nxt   = r_tgt;
    w_stp_nxt   = r_stp;
    w_done_nxt  = 1'b0;

    if (abort) begin
      w_state_nxt = IDLE;
      w_duty_nxt  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // A tick coinciding with acceptance is deliberately not acted on.
          if (cmd_valid) begin
            w_tgt_nxt   = (cmd_target > MAXD) ? MAXD : cmd_target;
            w_stp_nxt   = SW'(cmd_step);
            w_state_nxt = RAMP;
          end
        end
        RAMP: begin
          if (period_tick) begin
            if (r_stp == '0 || r_stp >= w_dist) begin
              w_duty_nxt  = r_tgt;
              w_done_nxt  = 1'b1;
              w_state_nxt = IDLE;
            end else if (r_tgt > r_duty) begin
              // r_stp < w_dist <= PERIOD here, so the low DW bits hold it exactly.
              w_duty_nxt = r_duty + r_stp[DW-1:0];
            end else begin
              w_duty_nxt = r_duty - r_stp[DW-1:0];
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Bench for pwm_ramp_ctrl: directed vector table, async-reset sequence, then random traffic vs. a reference model.
module tb_pwm_ramp_ctrl;

  localparam int PERIOD = 100;
  localparam int STEP_W = 8;
  localparam int DW     = $clog2(PERIOD + 1);

  logic              clk;
  logic              reset_n;
  logic              period_tick;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DW-1:0]     cmd_target;
  logic [STEP_W-1:0] cmd_step;
  logic              abort;
  logic [DW-1:0]     duty;
  logic              busy;
  logic              done;

  pwm_ramp_ctrl #(.PERIOD(PERIOD), .STEP_W(STEP_W)) dut (
    .clk(clk), .reset_n(reset_n), .period_tick(period_tick),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_step(cmd_step), .abort(abort), .duty(duty), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state: where the duty is, where it is headed, how fast.
  int m_duty, m_tgt, m_stp, m_busy, m_done;
  int s_rdy;

  typedef struct {
    logic tick;
    logic valid;
    int   target;
    int   step;
    logic ab;
    int   e_rdy;
    int   e_duty;
    int   e_busy;
    int   e_done;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic t, logic v, int tg, int st, logic ab,
                              int rdy, int d, int b, int dn);
    vec_t r;
    r.tick = t; r.valid = v; r.target = tg; r.step = st; r.ab = ab;
    r.e_rdy = rdy; r.e_duty = d; r.e_busy = b; r.e_done = dn;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_duty = 0; m_tgt = 0; m_stp = 0; m_busy = 0; m_done = 0;
  endtask

  // Duty moves toward the target by at most one step per tick; step 0 jumps straight there.
  task automatic model_edge(input logic t, input logic v, input int tg, input int st, input logic ab);
    int nd;
    m_done = 0;
    if (ab) begin
      m_duty = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (v) begin
        m_tgt  = (tg > PERIOD) ? PERIOD : tg;
        m_stp  = st;
        m_busy = 1;
      end
    end else if (t) begin
      if (m_stp == 0)           nd = m_tgt;
      else if (m_tgt > m_duty)  nd = (m_duty + m_stp > m_tgt) ? m_tgt : m_duty + m_stp;
      else                      nd = (m_duty - m_stp < m_tgt) ? m_tgt : m_duty - m_stp;
      m_duty = nd;
      if (nd == m_tgt) begin
        m_done = 1;
        m_busy = 0;
      end
    end
  endtask

  // Called at posedge+1: drive, sample ready, clock once, land at posedge+1 again.
  task automatic drive(input logic t, input logic v, input int tg, input int st, input logic ab);
    period_tick = t;
    cmd_valid   = v;
    cmd_target  = DW'(tg);
    cmd_step    = STEP_W'(st);
    abort       = ab;
    #1;
    s_rdy = int'(cmd_ready);
    @(posedge clk);
    model_edge(t, v, tg, st, ab);
    #1;
  endtask

  task automatic idle_inputs();
    period_tick = 1'b0; cmd_valid = 1'b0; cmd_target = '0; cmd_step = '0; abort = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset duty", int'(duty), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset ready", int'(cmd_ready), 1);

    // Ramp up 0 -> 50 by 10
    vt.push_back(mk(0, 1, 50, 10, 0, 1,  0, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 10, 1, 0));
    vt.push_back(mk(0, 0,  0,  0, 0, 0, 10, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 20, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 30, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 40, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 50, 0, 1));
    vt.push_back(mk(0, 0,  0,  0, 0, 1, 50, 0, 0));
    // Ramp down 50 -> 3 by 20, last step is the remainder
    vt.push_back(mk(0, 1,  3, 20, 0, 1, 50, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 30, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 10, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0,  3, 0, 1));
    vt.push_back(mk(0, 0,  0,  0, 0, 1,  3, 0, 0));
    // Clamped target with step 0, tick on the accept edge ignored
    vt.push_back(mk(1, 1, 120, 0, 0, 1,   3, 1, 0));
    vt.push_back(mk(1, 0,   0, 0, 0, 0, 100, 0, 1));
    vt.push_back(mk(0, 0,   0, 0, 0, 1, 100, 0, 0));
    // Abort from idle, then abort mid-ramp with a competing command
    vt.push_back(mk(0, 0,  0,  0, 1, 0,  0, 0, 0));
    vt.push_back(mk(0, 1, 80, 10, 0, 1,  0, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 10, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 20, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 30, 1, 0));
    vt.push_back(mk(1, 1,  5,  1, 1, 0,  0, 0, 0));
    vt.push_back(mk(0, 0,  0,  0, 0, 1,  0, 0, 0));
    // Command held during a ramp stalls until idle
    vt.push_back(mk(0, 1, 20, 10, 0, 1,  0, 1, 0));
    vt.push_back(mk(1, 1,  5,  5, 0, 0, 10, 1, 0));
    vt.push_back(mk(1, 1,  5,  5, 0, 0, 20, 0, 1));
    vt.push_back(mk(0, 1,  5,  5, 0, 1, 20, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 15, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0, 10, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0,  5, 0, 1));
    // Target equal to current duty: still one tick, then done
    vt.push_back(mk(0, 1,  5,  3, 0, 1,  5, 1, 0));
    vt.push_back(mk(0, 0,  0,  0, 0, 0,  5, 1, 0));
    vt.push_back(mk(1, 0,  0,  0, 0, 0,  5, 0, 1));
    vt.push_back(mk(0, 0,  0,  0, 0, 1,  5, 0, 0));
    // Abort held keeps duty and ready at zero
    vt.push_back(mk(1, 1, 60,  0, 1, 0,  0, 0, 0));
    vt.push_back(mk(1, 1, 60,  0, 1, 0,  0, 0, 0));
    vt.push_back(mk(0, 0,  0,  0, 0, 1,  0, 0, 0));

    foreach (vt[i]) begin
      drive(vt[i].tick, vt[i].valid, vt[i].target, vt[i].step, vt[i].ab);
      chk($sformatf("vec%0d ready", i), s_rdy,       vt[i].e_rdy);
      chk($sformatf("vec%0d duty",  i), int'(duty),  vt[i].e_duty);
      chk($sformatf("vec%0d busy",  i), int'(busy),  vt[i].e_busy);
      chk($sformatf("vec%0d done",  i), int'(done),  vt[i].e_done);
    end

    // Asynchronous reset between edges while ramping at duty 40
    drive(0, 1, 90, 40, 0);
    drive(1, 0, 0, 0, 0);
    chk("pre-reset duty", int'(duty), 40);
    chk("pre-reset busy", int'(busy), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async reset duty", int'(duty), 0);
    chk("async reset busy", int'(busy), 0);
    chk("async reset done", int'(done), 0);
    model_reset();
    idle_inputs();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release ready", int'(cmd_ready), 1);
    chk("release duty", int'(duty), 0);

    // Random traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      logic t, v, ab;
      int   tg, st, e_rdy;
      t  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 1) == 1);
      ab = ($urandom_range(0, 39) == 0);
      tg = $urandom_range(0, 127);
      st = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 45);
      e_rdy = (!m_busy && !ab) ? 1 : 0;
      drive(t, v, tg, st, ab);
      chk($sformatf("rnd%0d ready", i), s_rdy,      e_rdy);
      chk($sformatf("rnd%0d duty",  i), int'(duty), m_duty);
      chk($sformatf("rnd%0d busy",  i), int'(busy), m_busy);
      chk($sformatf("rnd%0d done",  i), int'(done), m_done);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
